// File: rtl/multi_dac_receiver_pkg.sv
// multi_dac_receiver_pkg: shared defaults and FSM encodings for the multi-lane I2S receiver
package multi_dac_receiver_pkg;
    localparam int DATA_BITS_DEF = 24;
    localparam int LANES_DEF = 2;
    localparam int CAPTURE_CLK_PERIOD_NS = 10;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAD = 2'd2;
endpackage

// File: rtl/pin_sync.sv
// pin_sync: SYNC_STAGES-deep flop chain bringing one asynchronous pin into the capture_clk domain
module pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic capture_clk,
    input  logic not_reset,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    always_comb sync_d = SYNC_STAGES'({sync_q, d});
    always_ff @(posedge capture_clk) begin
        if (!not_reset) sync_q <= '0;
        else sync_q <= sync_d;
    end
    assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/multi_dac_receiver.sv
// multi_dac_receiver: oversampled multi-lane I2S receiver assembling words and L/R frames
module multi_dac_receiver
    import multi_dac_receiver_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int LANES = LANES_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                         capture_clk,
    input  logic                         not_reset,
    input  logic                         enable,
    input  logic                         DAC_BCK,
    input  logic                         DAC_LRCK,
    input  logic [LANES-1:0]             DAC_DATA_PINS,
    output logic [LANES*DATA_BITS-1:0]   word_data,
    output logic                         word_lr,
    output logic                         word_valid,
    output logic [2*LANES*DATA_BITS-1:0] frame_data,
    output logic                         frame_valid,
    output logic                         short_word,
    output logic                         bck_lost,
    output logic [31:0]                  frame_count
);
    localparam int W = LANES * DATA_BITS;
    localparam int CW = $clog2(DATA_BITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic bck_s, lrck_s, bck_rise, lr_edge, tmo_hit;
    logic [LANES-1:0] data_s;
    logic [W-1:0] shifted;
    logic [2*W-1:0] framed;
    logic [1:0] state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic bck_prev_q, bck_prev_d, lr_ref_q, lr_ref_d, cur_lr_q, cur_lr_d, left_ok_q, left_ok_d;
    logic [W-1:0] shift_q, shift_d, left_q, left_d, word_data_q, word_data_d;
    logic [2*W-1:0] frame_data_q, frame_data_d;
    logic word_lr_q, word_lr_d, word_valid_q, word_valid_d, frame_valid_q, frame_valid_d;
    logic short_word_q, short_word_d, bck_lost_q, bck_lost_d;
    logic [31:0] frame_count_q, frame_count_d;

    pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bck (.capture_clk, .not_reset, .d(DAC_BCK), .q(bck_s));
    pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lrck (.capture_clk, .not_reset, .d(DAC_LRCK), .q(lrck_s));

    genvar i;
    generate
        for (i = 0; i < LANES; i++) begin : g_lane
            pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_data (.capture_clk, .not_reset, .d(DAC_DATA_PINS[i]), .q(data_s[i]));
            assign shifted[i*DATA_BITS +: DATA_BITS] = {shift_q[i*DATA_BITS +: DATA_BITS-1], data_s[i]};
            assign framed[2*i*DATA_BITS +: DATA_BITS] = left_q[i*DATA_BITS +: DATA_BITS];
            assign framed[(2*i+1)*DATA_BITS +: DATA_BITS] = shifted[i*DATA_BITS +: DATA_BITS];
        end
    endgenerate

    assign bck_rise = bck_s & ~bck_prev_q;
    assign lr_edge = bck_rise & (lrck_s ^ lr_ref_q);
    assign tmo_hit = (state_q != ST_IDLE) && !bck_rise && (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        bit_cnt_d = bit_cnt_q;
        bck_prev_d = bck_s;
        lr_ref_d = lr_ref_q;
        cur_lr_d = cur_lr_q;
        left_ok_d = left_ok_q;
        shift_d = shift_q;
        left_d = left_q;
        word_data_d = word_data_q;
        word_lr_d = word_lr_q;
        frame_data_d = frame_data_q;
        frame_count_d = frame_count_q;
        word_valid_d = 1'b0;
        frame_valid_d = 1'b0;
        short_word_d = 1'b0;
        bck_lost_d = 1'b0;
        tmo_d = (state_q == ST_IDLE || bck_rise) ? '0 : tmo_q + 1'b1;
        if (!enable || tmo_hit) begin
            state_d = ST_IDLE;
            bit_cnt_d = '0;
            tmo_d = '0;
            lr_ref_d = 1'b1;
            left_ok_d = 1'b0;
            bck_lost_d = enable;
        end else if (bck_rise) begin
            lr_ref_d = lrck_s;
            if (lr_edge) begin
                state_d = ST_SHIFT;
                bit_cnt_d = '0;
                cur_lr_d = lrck_s;
                short_word_d = state_q == ST_SHIFT;
                left_ok_d = (state_q == ST_SHIFT) ? 1'b0 : left_ok_q;
            end else if (state_q == ST_SHIFT) begin
                shift_d = shifted;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CW'(DATA_BITS - 1)) begin
                    state_d = ST_PAD;
                    word_valid_d = 1'b1;
                    word_data_d = shifted;
                    word_lr_d = cur_lr_q;
                    if (!cur_lr_q) begin
                        left_d = shifted;
                        left_ok_d = 1'b1;
                    end else if (left_ok_q) begin
                        frame_data_d = framed;
                        frame_valid_d = 1'b1;
                        frame_count_d = frame_count_q + 1'b1;
                        left_ok_d = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge capture_clk) begin
        if (!not_reset) begin
            state_q <= ST_IDLE;
            bit_cnt_q <= '0;
            tmo_q <= '0;
            bck_prev_q <= 1'b0;
            lr_ref_q <= 1'b1;
            cur_lr_q <= 1'b0;
            left_ok_q <= 1'b0;
            shift_q <= '0;
            left_q <= '0;
            word_data_q <= '0;
            word_lr_q <= 1'b0;
            word_valid_q <= 1'b0;
            frame_data_q <= '0;
            frame_valid_q <= 1'b0;
            short_word_q <= 1'b0;
            bck_lost_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tmo_q <= tmo_d;
            bck_prev_q <= bck_prev_d;
            lr_ref_q <= lr_ref_d;
            cur_lr_q <= cur_lr_d;
            left_ok_q <= left_ok_d;
            shift_q <= shift_d;
            left_q <= left_d;
            word_data_q <= word_data_d;
            word_lr_q <= word_lr_d;
            word_valid_q <= word_valid_d;
            frame_data_q <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            short_word_q <= short_word_d;
            bck_lost_q <= bck_lost_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign word_data = word_data_q;
    assign word_lr = word_lr_q;
    assign word_valid = word_valid_q;
    assign frame_data = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign short_word = short_word_q;
    assign bck_lost = bck_lost_q;
    assign frame_count = frame_count_q;
endmodule

// File: tb/tb_multi_dac_receiver.sv
// tb_multi_dac_receiver: directed vector table plus corner sequences for multi_dac_receiver
module tb_multi_dac_receiver;
    import multi_dac_receiver_pkg::*;

    logic clk = 1'b0;
    logic not_reset = 1'b0;
    logic enable = 1'b1;
    logic bck = 1'b0;
    logic lrck = 1'b1;
    logic [1:0] pins = 2'b00;
    logic [47:0] word_data;
    logic word_lr, word_valid, frame_valid, short_word, bck_lost;
    logic [95:0] frame_data;
    logic [31:0] frame_count;

    int n_chk = 0, n_fail = 0;
    int wv_cnt = 0, fv_cnt = 0, sw_cnt = 0, bl_cnt = 0, fv_alone = 0;
    logic [47:0] last_l = '0;

    multi_dac_receiver dut (
        .capture_clk(clk), .not_reset(not_reset), .enable(enable),
        .DAC_BCK(bck), .DAC_LRCK(lrck), .DAC_DATA_PINS(pins),
        .word_data(word_data), .word_lr(word_lr), .word_valid(word_valid),
        .frame_data(frame_data), .frame_valid(frame_valid), .short_word(short_word),
        .bck_lost(bck_lost), .frame_count(frame_count)
    );

    always #(CAPTURE_CLK_PERIOD_NS / 2) clk = ~clk;

    always @(negedge clk) begin
        if (word_valid) begin
            wv_cnt++;
            if (!word_lr) last_l = word_data;
        end
        if (frame_valid) fv_cnt++;
        if (frame_valid && !word_valid) fv_alone++;
        if (short_word) sw_cnt++;
        if (bck_lost) bl_cnt++;
    end

    typedef struct {
        logic [23:0] l0, l1, r0, r1;
        int pad;
        logic [95:0] frame;
        logic [31:0] count;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bck_bit(input logic lr, input logic [1:0] d);
        lrck = lr;
        pins = d;
        repeat (2) @(negedge clk);
        bck = 1'b1;
        repeat (2) @(negedge clk);
        bck = 1'b0;
    endtask

    task automatic send_half(input logic lr, input logic [23:0] w0, input logic [23:0] w1, input int nbits, input int pad);
        bck_bit(lr, 2'b00);
        for (int b = 0; b < nbits; b++) bck_bit(lr, {w1[23-b], w0[23-b]});
        for (int b = 0; b < pad; b++) bck_bit(lr, 2'b11);
    endtask

    task automatic send_frame(input logic [23:0] l0, input logic [23:0] l1, input logic [23:0] r0, input logic [23:0] r1, input int pad);
        send_half(1'b0, l0, l1, 24, pad);
        send_half(1'b1, r0, r1, 24, pad);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int wv0, fv0, sw0, bl0;
        vecs[0] = '{24'hA1B0C1, 24'hC1D0A1, 24'h0F1E2D, 24'hFFFFFF, 0, 96'hFFFFFF_C1D0A1_0F1E2D_A1B0C1, 32'd1};
        vecs[1] = '{24'h000000, 24'h800001, 24'h7FFFFE, 24'h000000, 0, 96'h000000_800001_7FFFFE_000000, 32'd2};
        vecs[2] = '{24'h123456, 24'hABCDEF, 24'hFEDCBA, 24'h654321, 8, 96'h654321_ABCDEF_FEDCBA_123456, 32'd3};
        vecs[3] = '{24'h555555, 24'hAAAAAA, 24'hC3C3C3, 24'h3C3C3C, 8, 96'h3C3C3C_AAAAAA_C3C3C3_555555, 32'd4};

        repeat (3) @(negedge clk);
        check("rst word_data", word_data, 0);
        check("rst word_valid", word_valid, 0);
        check("rst frame_data", frame_data, 0);
        check("rst frame_valid", frame_valid, 0);
        check("rst short_word", short_word, 0);
        check("rst bck_lost", bck_lost, 0);
        check("rst frame_count", frame_count, 0);
        not_reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            wv0 = wv_cnt;
            fv0 = fv_cnt;
            send_frame(vecs[v].l0, vecs[v].l1, vecs[v].r0, vecs[v].r1, vecs[v].pad);
            check($sformatf("vec%0d left word", v), last_l, {vecs[v].l1, vecs[v].l0});
            check($sformatf("vec%0d right word", v), word_data, {vecs[v].r1, vecs[v].r0});
            check($sformatf("vec%0d word_lr", v), word_lr, 1);
            check($sformatf("vec%0d word_valid pulses", v), wv_cnt - wv0, 2);
            check($sformatf("vec%0d frame_valid pulses", v), fv_cnt - fv0, 1);
            check($sformatf("vec%0d frame_data", v), frame_data, vecs[v].frame);
            check($sformatf("vec%0d frame_count", v), frame_count, vecs[v].count);
        end

        wv0 = wv_cnt; fv0 = fv_cnt; sw0 = sw_cnt;
        send_half(1'b0, 24'h111111, 24'h222222, 24, 0);
        send_half(1'b1, 24'h333333, 24'h444444, 10, 0);
        send_half(1'b0, 24'h555555, 24'h666666, 10, 0);
        send_half(1'b1, 24'h9ABCDE, 24'h13579B, 24, 0);
        repeat (4) @(negedge clk);
        check("short pulses", sw_cnt - sw0, 2);
        check("short word_valid pulses", wv_cnt - wv0, 2);
        check("short next word", word_data, 48'h13579B_9ABCDE);
        check("short orphan no frame", fv_cnt - fv0, 0);
        check("short frame_count", frame_count, 4);
        send_frame(24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C, 0);
        check("post-short frame_data", frame_data, 96'h0A0B0C_040506_070809_010203);
        check("post-short frame_count", frame_count, 5);

        wv0 = wv_cnt; sw0 = sw_cnt; bl0 = bl_cnt;
        send_half(1'b0, 24'hDEADBE, 24'hBEEFED, 12, 0);
        repeat (300) @(negedge clk);
        check("lost pulses", bl_cnt - bl0, 1);
        check("lost no word", wv_cnt - wv0, 0);
        check("lost no short", sw_cnt - sw0, 0);
        check("lost frame_count", frame_count, 5);
        send_frame(24'hF00F00, 24'h0FF0FF, 24'h00FF00, 24'hFF00FF, 0);
        check("resync frame_data", frame_data, 96'hFF00FF_0FF0FF_00FF00_F00F00);
        check("resync frame_count", frame_count, 6);

        wv0 = wv_cnt; sw0 = sw_cnt; bl0 = bl_cnt;
        send_half(1'b0, 24'h101010, 24'h202020, 24, 0);
        send_half(1'b1, 24'h303030, 24'h404040, 10, 0);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        check("enable drop words", wv_cnt - wv0, 1);
        check("enable drop no short", sw_cnt - sw0, 0);
        check("enable drop no lost", bl_cnt - bl0, 0);
        check("enable drop frame_count", frame_count, 6);
        send_frame(24'h876543, 24'h234567, 24'hFEDCBA, 24'h0C0C0C, 0);
        check("post-enable frame_data", frame_data, 96'h0C0C0C_234567_FEDCBA_876543);
        check("post-enable frame_count", frame_count, 7);

        send_half(1'b0, 24'hCAFE12, 24'h34BABE, 10, 0);
        not_reset = 1'b0;
        @(negedge clk);
        not_reset = 1'b1;
        check("midrst word_data", word_data, 0);
        check("midrst word_lr", word_lr, 0);
        check("midrst frame_data", frame_data, 0);
        check("midrst frame_count", frame_count, 0);
        repeat (2) @(negedge clk);
        send_frame(24'hA1B0C1, 24'hC1D0A1, 24'h0F1E2D, 24'hFFFFFF, 0);
        check("after rst frame_data", frame_data, 96'hFFFFFF_C1D0A1_0F1E2D_A1B0C1);
        check("after rst frame_count", frame_count, 1);
        check("frame_valid alone", fv_alone, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
